// File: rtl/bomber_pkg.sv
// Shared screen geometry, explosion state encoding and coordinate/sprite helpers.
package bomber_pkg;

  localparam int unsigned COORD_W  = 11;
  localparam int unsigned SPRITE_W = 4;

  localparam int HACTIVE = 800;
  localparam int VACTIVE = 600;
  localparam int TILE    = 32;

  // Off-screen origin makes the renderer's rectangle test fail.
  localparam logic signed [COORD_W-1:0] OFFSCREEN = -11'sd64;

  localparam logic signed [COORD_W-1:0] X_MAX = COORD_W'(HACTIVE - TILE);
  localparam logic signed [COORD_W-1:0] Y_MAX = COORD_W'(VACTIVE - TILE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    BURN = 2'd2,
    DONE = 2'd3
  } expl_state_e;

  // Clamp a tile origin to 0..hi; negative values map to 0.
  function automatic logic signed [COORD_W-1:0] clamp_coord(
    input logic signed [COORD_W-1:0] v,
    input logic signed [COORD_W-1:0] hi
  );
    if (v[COORD_W-1]) begin
      return '0;
    end
    if (v > hi) begin
      return hi;
    end
    return v;
  endfunction

  // Map a burn step 0..2*(n-1) onto the up/down sprite sequence 0..n-1..0.
  function automatic logic [SPRITE_W-1:0] flame_sprite(
    input logic [2:0]  step,
    input int unsigned n_steps
  );
    if (32'(step) < n_steps) begin
      return SPRITE_W'(step);
    end
    return SPRITE_W'(2 * (n_steps - 1) - 32'(step));
  endfunction

endpackage

// File: rtl/tick_div.sv
// Frame-tick prescaler: one-cycle step_tick every DIV enabled frame ticks.
module tick_div #(
  parameter int unsigned DIV = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic frame_tick,
  output logic step_tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt;

  // Count enabled frame ticks; clr restarts the count so the first step is full length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      step_tick <= 1'b0;
    end else if (clr) begin
      cnt       <= '0;
      step_tick <= 1'b0;
    end else begin
      step_tick <= 1'b0;
      if (en && frame_tick) begin
        if (cnt == CNT_W'(DIV - 1)) begin
          cnt       <= '0;
          step_tick <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/explosion_ctrl.sv
// Bomb explosion sequencer: arm/fuse, flame animation and done pulse.
// Optional fuse stage (ARM state, fuse counter, chain_hit) enabled by EXPLOSION_FUSE_EN.
module explosion_ctrl
  import bomber_pkg::*;
#(
  parameter int unsigned FUSE_FRAMES = 120,
  parameter int unsigned STEP_FRAMES = 8,
  parameter int unsigned N_STEPS     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_tick,
  input  logic                      bomb_req,
  input  logic signed [COORD_W-1:0] bomb_x,
  input  logic signed [COORD_W-1:0] bomb_y,
  input  logic                      chain_hit,
  output logic                      busy,
  output logic signed [COORD_W-1:0] centerX,
  output logic signed [COORD_W-1:0] centerY,
  output logic [SPRITE_W-1:0]       sprite_num,
  output logic                      flame_active,
  output logic                      done
);

  localparam int unsigned STEP_W    = 3;
  localparam int unsigned LAST_STEP = 2 * N_STEPS - 2;

  expl_state_e               state, state_d;
  logic [STEP_W-1:0]         step_idx, step_d;
  logic signed [COORD_W-1:0] lat_x, lat_x_d;
  logic signed [COORD_W-1:0] lat_y, lat_y_d;

  logic                      busy_d, flame_d, done_d;
  logic [SPRITE_W-1:0]       sprite_d;
  logic signed [COORD_W-1:0] center_x_d, center_y_d;

  logic                      step_tick;
  logic                      burn_entry_c;
  logic                      tick_en_c;

`ifdef EXPLOSION_FUSE_EN
  localparam int unsigned FUSE_W = $clog2(FUSE_FRAMES + 1);

  logic [FUSE_W-1:0] fuse_cnt, fuse_d;
`else
  // No fuse stage: chain_hit and the fuse length have no consumer.
  logic unused_fuse_cfg;
  assign unused_fuse_cfg = &{1'b0, chain_hit, 32'(FUSE_FRAMES)};
`endif

  tick_div #(
    .DIV (STEP_FRAMES)
  ) u_tick_div (
    .clk        (clk),
    .rst        (rst),
    .clr        (burn_entry_c),
    .en         (tick_en_c),
    .frame_tick (frame_tick),
    .step_tick  (step_tick)
  );

  // Next state, latched coordinates and next values of the registered outputs.
  always_comb begin
    state_d = state;
    step_d  = step_idx;
    lat_x_d = lat_x;
    lat_y_d = lat_y;
`ifdef EXPLOSION_FUSE_EN
    fuse_d  = fuse_cnt;
`endif

    case (state)
      IDLE: begin
        if (bomb_req) begin
          lat_x_d = clamp_coord(bomb_x, X_MAX);
          lat_y_d = clamp_coord(bomb_y, Y_MAX);
          step_d  = '0;
`ifdef EXPLOSION_FUSE_EN
          fuse_d  = FUSE_W'(FUSE_FRAMES);
          state_d = ARM;
`else
          state_d = BURN;
`endif
        end
      end
      ARM: begin
`ifdef EXPLOSION_FUSE_EN
        // A chain hit preempts the fuse, even on a coincident frame tick.
        if (chain_hit) begin
          fuse_d  = '0;
          state_d = BURN;
        end else if (frame_tick) begin
          if (fuse_cnt <= FUSE_W'(1)) begin
            fuse_d  = '0;
            state_d = BURN;
          end else begin
            fuse_d = fuse_cnt - FUSE_W'(1);
          end
        end
`else
        state_d = IDLE;
`endif
      end
      BURN: begin
        if (step_tick) begin
          if (step_idx == STEP_W'(LAST_STEP)) begin
            state_d = DONE;
          end else begin
            step_d = step_idx + STEP_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d     = (state_d != IDLE);
    flame_d    = (state_d == BURN);
    done_d     = (state_d == DONE);
    sprite_d   = flame_d ? flame_sprite(step_d, N_STEPS) : '0;
    center_x_d = flame_d ? lat_x_d : OFFSCREEN;
    center_y_d = flame_d ? lat_y_d : OFFSCREEN;

    burn_entry_c = flame_d && (state != BURN);
    tick_en_c    = (state == BURN);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      step_idx     <= '0;
      lat_x        <= '0;
      lat_y        <= '0;
`ifdef EXPLOSION_FUSE_EN
      fuse_cnt     <= '0;
`endif
      busy         <= 1'b0;
      flame_active <= 1'b0;
      done         <= 1'b0;
      sprite_num   <= '0;
      centerX      <= OFFSCREEN;
      centerY      <= OFFSCREEN;
    end else begin
      state        <= state_d;
      step_idx     <= step_d;
      lat_x        <= lat_x_d;
      lat_y        <= lat_y_d;
`ifdef EXPLOSION_FUSE_EN
      fuse_cnt     <= fuse_d;
`endif
      busy         <= busy_d;
      flame_active <= flame_d;
      done         <= done_d;
      sprite_num   <= sprite_d;
      centerX      <= center_x_d;
      centerY      <= center_y_d;
    end
  end

endmodule

// File: tb/tb_explosion_ctrl.sv
// Scoreboard bench for explosion_ctrl: expected bursts queued at request time,
// checked by a monitor as the flame sequence plays out.
module tb_explosion_ctrl;

  localparam int unsigned FUSE = 3;
  localparam int unsigned STEP = 2;
  localparam int unsigned NS   = 4;
  localparam int          LAST = 2 * NS - 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               frame_tick;
  logic               bomb_req;
  logic signed [10:0] bomb_x;
  logic signed [10:0] bomb_y;
  logic               chain_hit;
  logic               busy;
  logic signed [10:0] centerX;
  logic signed [10:0] centerY;
  logic [3:0]         sprite_num;
  logic               flame_active;
  logic               done;

  typedef struct {
    int x;
    int y;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   seq[7] = '{0, 1, 2, 3, 2, 1, 0};

  int checks     = 0;
  int errors     = 0;
  int dones      = 0;
  int exp_dones  = 0;
  int tick_cnt   = 0;
  int step_start = 0;
  int ptr        = 0;
  int phase      = 0;
  int prev_sprite = 0;
  bit prev_flame = 1'b0;
  bit aborting   = 1'b0;

  explosion_ctrl #(
    .FUSE_FRAMES (FUSE),
    .STEP_FRAMES (STEP),
    .N_STEPS     (NS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .bomb_req     (bomb_req),
    .bomb_x       (bomb_x),
    .bomb_y       (bomb_y),
    .chain_hit    (chain_hit),
    .busy         (busy),
    .centerX      (centerX),
    .centerY      (centerY),
    .sprite_num   (sprite_num),
    .flame_active (flame_active),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock; frame_tick every 4th cycle, request pulses cleared afterwards.
  task automatic step_clk();
    frame_tick = (phase % 4 == 0);
    phase++;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    bomb_req   = 1'b0;
    chain_hit  = 1'b0;
  endtask

  task automatic send_bomb(input int x, input int y, input int ex, input int ey);
    bomb_x = 11'(x);
    bomb_y = 11'(y);
    exp_q.push_back(exp_t'{ex, ey});
    bomb_req = 1'b1;
    step_clk();
  endtask

  task automatic wait_sprite(input int v);
    int n = 0;
    while (!(flame_active === 1'b1 && int'(sprite_num) == v) && n < 300) begin
      step_clk();
      n++;
    end
    check("wait_sprite_timeout", int'(n < 300), 1);
  endtask

  task automatic run_to_done();
    int n = 0;
    do begin
      step_clk();
      n++;
    end while (done !== 1'b1 && n < 300);
    check("done_seen", int'(done === 1'b1), 1);
  endtask

  // Frame ticks the DUT can see while burning.
  always @(posedge clk) begin
    if (flame_active === 1'b1 && frame_tick === 1'b1) tick_cnt = tick_cnt + 1;
  end

  // Monitor: pop an expectation at each burn start, follow the sprite sequence.
  always @(negedge clk) begin
    if (flame_active === 1'b1 && !prev_flame) begin
      check("burn_has_exp", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) cur = exp_q.pop_front();
      ptr        = 0;
      step_start = tick_cnt;
      check("burn_first_sprite", int'(sprite_num), 0);
    end else if (flame_active === 1'b1 && int'(sprite_num) != prev_sprite) begin
      check("step_len", tick_cnt - step_start, STEP);
      ptr++;
      step_start = tick_cnt;
      check("sprite_seq", int'(sprite_num), (ptr <= LAST) ? seq[ptr] : -1);
    end
    if (flame_active === 1'b1) begin
      check("burn_cx", int'(centerX), cur.x);
      check("burn_cy", int'(centerY), cur.y);
    end
    if (flame_active === 1'b0 && prev_flame && !aborting) begin
      check("last_step_len", tick_cnt - step_start, STEP);
      check("last_step_idx", ptr, LAST);
      check("done_at_end", int'(done), 1);
    end
    if (done === 1'b1) dones++;
    prev_flame  = (flame_active === 1'b1);
    prev_sprite = int'(sprite_num);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    frame_tick = 1'b0;
    bomb_req   = 1'b0;
    chain_hit  = 1'b0;
    bomb_x     = '0;
    bomb_y     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",   int'(busy), 0);
    check("rst_flame",  int'(flame_active), 0);
    check("rst_done",   int'(done), 0);
    check("rst_sprite", int'(sprite_num), 0);
    check("rst_cx",     int'(centerX), -64);
    check("rst_cy",     int'(centerY), -64);
    rst = 1'b0;
    repeat (2) step_clk();

    // Nominal burst with requests overlapping every busy phase.
    send_bomb(100, 200, 100, 200);
`ifdef EXPLOSION_FUSE_EN
    check("arm_busy",  int'(busy), 1);
    check("arm_flame", int'(flame_active), 0);
    check("arm_cx",    int'(centerX), -64);
    bomb_x   = 11'sd7;
    bomb_y   = 11'sd7;
    bomb_req = 1'b1;
    step_clk();
`else
    check("accept_flame", int'(flame_active), 1);
    check("accept_busy",  int'(busy), 1);
    check("accept_cx",    int'(centerX), 100);
    check("accept_cy",    int'(centerY), 200);
`endif
    wait_sprite(2);
    bomb_x    = 11'sd9;
    bomb_y    = 11'sd9;
    bomb_req  = 1'b1;
    chain_hit = 1'b1;
    step_clk();
    run_to_done();
    exp_dones++;
    check("done_busy",  int'(busy), 1);
    check("done_flame", int'(flame_active), 0);
    bomb_x   = 11'sd11;
    bomb_y   = 11'sd11;
    bomb_req = 1'b1;
    step_clk();
    check("post_done_pulse", int'(done), 0);
    check("post_done_busy",  int'(busy), 0);
    check("post_done_cx",    int'(centerX), -64);
    repeat (3) step_clk();
    check("req_in_done_ignored", int'(busy), 0);

    // Clamping at both ends of each axis.
    send_bomb(790, -5, 768, 0);
    run_to_done();
    exp_dones++;
    repeat (2) step_clk();
    send_bomb(-20, 900, 0, 568);
    run_to_done();
    exp_dones++;
    repeat (2) step_clk();

`ifdef EXPLOSION_FUSE_EN
    // Chain hit on a non-final fuse tick.
    send_bomb(50, 60, 50, 60);
    while (phase % 4 != 0) step_clk();
    chain_hit = 1'b1;
    step_clk();
    check("chain_flame",  int'(flame_active), 1);
    check("chain_sprite", int'(sprite_num), 0);
    check("chain_cx",     int'(centerX), 50);
    run_to_done();
    exp_dones++;
    repeat (2) step_clk();
`else
    // chain_hit has no effect without the fuse stage.
    chain_hit = 1'b1;
    step_clk();
    check("chain_idle_busy",  int'(busy), 0);
    check("chain_idle_flame", int'(flame_active), 0);
    send_bomb(50, 60, 50, 60);
    check("accept2_flame", int'(flame_active), 1);
    run_to_done();
    exp_dones++;
    repeat (2) step_clk();
`endif

    // Reset in the middle of the burn: abandoned, no done pulse.
    send_bomb(400, 300, 400, 300);
    wait_sprite(3);
    aborting = 1'b1;
    rst      = 1'b1;
    #1;
    check("abort_cx",     int'(centerX), -64);
    check("abort_cy",     int'(centerY), -64);
    check("abort_busy",   int'(busy), 0);
    check("abort_flame",  int'(flame_active), 0);
    check("abort_done",   int'(done), 0);
    check("abort_sprite", int'(sprite_num), 0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    aborting = 1'b0;
    step_clk();
    send_bomb(700, 500, 700, 500);
    check("post_abort_busy", int'(busy), 1);
    run_to_done();
    exp_dones++;
    repeat (3) step_clk();

    check("done_count", dones, exp_dones);
    check("queue_empty", int'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
